eth_reset_scheduler: RTL and testbench

Arbitrated sequencer for the Ethernet PHY hard-reset line. Several requesters (link watchdog, software register, MAC error monitor, etc.) can each ask for a PHY reset. The block merges and round-robins these requests, then runs one delay → pulse → recovery-check sequence at a time. Failed recoveries are retried, and a hold-off period separates consecutive resets. It sits between the requesters and the PHY reset pin, and reports per-request completion status.

---
 rtl/eth_reset_scheduler_if.sv | 39 +++
 rtl/eth_reset_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_eth_reset_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_reset_scheduler_if.sv
`timescale 1ns/1ps
// Requester, configuration and status bundle for eth_reset_scheduler.
// The master side drives requests and config; the slave side is the scheduler.
interface eth_reset_scheduler_if #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned TIMER_MAX_WIDTH = 14,
    parameter int unsigned RESET_MAX_WIDTH = 14,
    parameter int unsigned TIMEOUT_WIDTH   = 24,
    parameter int unsigned HOLDOFF_WIDTH   = 16,
    parameter int unsigned MAX_RETRY       = 2
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [NUM_REQ-1:0]         req;
    logic [TIMER_MAX_WIDTH-1:0] reset_after;
    logic [RESET_MAX_WIDTH-1:0] reset_width;
    logic [TIMEOUT_WIDTH-1:0]   recover_timeout;
    logic [HOLDOFF_WIDTH-1:0]   holdoff;
    logic                       link_up;

    logic                       eth_reset;
    logic                       busy;
    logic [IDW-1:0]             grant_id;
    logic                       done;
    logic [IDW-1:0]             done_id;
    logic                       done_ok;
    logic [RCW-1:0]             retry_count;

    modport master (
        output req, reset_after, reset_width, recover_timeout, holdoff, link_up,
        input  eth_reset, busy, grant_id, done, done_id, done_ok, retry_count
    );

    modport slave (
        input  req, reset_after, reset_width, recover_timeout, holdoff, link_up,
        output eth_reset, busy, grant_id, done, done_id, done_ok, retry_count
    );
endinterface

// File: rtl/eth_reset_scheduler.sv
`timescale 1ns/1ps
// Arbitrated PHY hard-reset sequencer: round-robin grant, then delay/pulse/recovery check
// with bounded retries, then a hold-off before the next requester is served.
module eth_reset_scheduler #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned TIMER_MAX_WIDTH = 14,
    parameter int unsigned RESET_MAX_WIDTH = 14,
    parameter int unsigned TIMEOUT_WIDTH   = 24,
    parameter int unsigned HOLDOFF_WIDTH   = 16,
    parameter int unsigned MAX_RETRY       = 2,
    parameter bit          OUT_ACTIVE      = 1'b1
) (
    input logic                  clk,
    input logic                  aresetn,
    eth_reset_scheduler_if.slave bus
);
    localparam int unsigned IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned RCW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned CW_A = (TIMER_MAX_WIDTH > RESET_MAX_WIDTH) ?
                                   TIMER_MAX_WIDTH : RESET_MAX_WIDTH;
    localparam int unsigned CW_B = (TIMEOUT_WIDTH > HOLDOFF_WIDTH) ? TIMEOUT_WIDTH : HOLDOFF_WIDTH;
    localparam int unsigned CW   = (CW_A > CW_B) ? CW_A : CW_B;
    localparam logic [RCW-1:0] RetryLimit = RCW'(MAX_RETRY);

    typedef enum logic [2:0] {StIdle, StDelay, StAssert, StRecover, StCooldown} state_e;

    state_e                     state_q;
    logic [CW-1:0]              cnt_q;
    logic [NUM_REQ-1:0]         pending_q;
    logic [IDW-1:0]             ptr_q;
    logic                       dropped_q;
    logic                       link_meta_q;
    logic                       link_s_q;

    logic [TIMER_MAX_WIDTH-1:0] cfg_after_q;
    logic [RESET_MAX_WIDTH-1:0] cfg_width_q;
    logic [TIMEOUT_WIDTH-1:0]   cfg_timeout_q;
    logic [HOLDOFF_WIDTH-1:0]   cfg_holdoff_q;

    logic                       eth_reset_q;
    logic                       busy_q;
    logic [IDW-1:0]             grant_id_q;
    logic                       done_q;
    logic [IDW-1:0]             done_id_q;
    logic                       done_ok_q;
    logic [RCW-1:0]             retry_q;

    logic                       pick_valid;
    logic [IDW-1:0]             pick_id;
    logic                       grant_fire;
    logic [NUM_REQ-1:0]         grant_mask;
    logic [RESET_MAX_WIDTH-1:0] width_m1;
    logic                       cnt_zero;

    assign bus.eth_reset   = eth_reset_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.done        = done_q;
    assign bus.done_id     = done_id_q;
    assign bus.done_ok     = done_ok_q;
    assign bus.retry_count = retry_q;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned k);
        return IDW'((32'(base) + k) % NUM_REQ);
    endfunction

    // Walk downward so the nearest set bit after the pointer is the last one written.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            if (pending_q[rr_idx(ptr_q, k)]) begin
                pick_valid = 1'b1;
                pick_id    = rr_idx(ptr_q, k);
            end
        end
    end

    assign grant_fire = (state_q == StIdle) && pick_valid;
    assign grant_mask = grant_fire ? (NUM_REQ'(1) << pick_id) : '0;
    assign width_m1   = (cfg_width_q == '0) ? '0 : cfg_width_q - RESET_MAX_WIDTH'(1);
    assign cnt_zero   = (cnt_q == '0);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            link_meta_q <= 1'b0;
            link_s_q    <= 1'b0;
        end else begin
            link_meta_q <= bus.link_up;
            link_s_q    <= link_meta_q;
        end
    end

    // A new request in the same cycle as its grant survives the clear.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~grant_mask) | bus.req;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ptr_q         <= IDW'(NUM_REQ - 1);
            dropped_q     <= 1'b0;
            cfg_after_q   <= '0;
            cfg_width_q   <= '0;
            cfg_timeout_q <= '0;
            cfg_holdoff_q <= '0;
            eth_reset_q   <= ~OUT_ACTIVE;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
            done_q        <= 1'b0;
            done_id_q     <= '0;
            done_ok_q     <= 1'b0;
            retry_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        ptr_q         <= pick_id;
                        grant_id_q    <= pick_id;
                        busy_q        <= 1'b1;
                        retry_q       <= '0;
                        cfg_after_q   <= bus.reset_after;
                        cfg_width_q   <= bus.reset_width;
                        cfg_timeout_q <= bus.recover_timeout;
                        cfg_holdoff_q <= bus.holdoff;
                        cnt_q         <= CW'(bus.reset_after);
                        state_q       <= StDelay;
                    end
                end
                StDelay: begin
                    if (cnt_zero) begin
                        eth_reset_q <= OUT_ACTIVE;
                        cnt_q       <= CW'(width_m1);
                        dropped_q   <= 1'b0;
                        state_q     <= StAssert;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StAssert: begin
                    if (!link_s_q) dropped_q <= 1'b1;
                    if (cnt_zero) begin
                        eth_reset_q <= ~OUT_ACTIVE;
                        cnt_q       <= CW'(cfg_timeout_q);
                        state_q     <= StRecover;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StRecover: begin
                    if (!link_s_q) dropped_q <= 1'b1;
                    // Success needs a low seen since the pulse began, then link back up.
                    if (link_s_q && dropped_q) begin
                        done_q    <= 1'b1;
                        done_id_q <= grant_id_q;
                        done_ok_q <= 1'b1;
                        cnt_q     <= CW'(cfg_holdoff_q);
                        state_q   <= StCooldown;
                    end else if (cnt_zero && (retry_q < RetryLimit)) begin
                        retry_q <= retry_q + RCW'(1);
                        cnt_q   <= CW'(cfg_after_q);
                        state_q <= StDelay;
                    end else if (cnt_zero) begin
                        done_q    <= 1'b1;
                        done_id_q <= grant_id_q;
                        done_ok_q <= 1'b0;
                        cnt_q     <= CW'(cfg_holdoff_q);
                        state_q   <= StCooldown;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StCooldown: begin
                    if (cnt_zero) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_reset_scheduler.sv
`timescale 1ns/1ps
// Directed bench for eth_reset_scheduler: a negedge monitor stamps pulse, busy and done
// events with the clock-edge index; each scenario task checks the stamps against hand values.
module tb_eth_reset_scheduler;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned IDW       = 2;
    localparam int unsigned RCW       = 2;
    localparam int unsigned LOG       = 64;

    logic clk     = 1'b0;
    logic aresetn = 1'b0;
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;

    eth_reset_scheduler_if #(
        .NUM_REQ(NUM_REQ), .TIMER_MAX_WIDTH(14), .RESET_MAX_WIDTH(14),
        .TIMEOUT_WIDTH(24), .HOLDOFF_WIDTH(16), .MAX_RETRY(MAX_RETRY)
    ) bus ();

    eth_reset_scheduler #(
        .NUM_REQ(NUM_REQ), .TIMER_MAX_WIDTH(14), .RESET_MAX_WIDTH(14),
        .TIMEOUT_WIDTH(24), .HOLDOFF_WIDTH(16), .MAX_RETRY(MAX_RETRY), .OUT_ACTIVE(1'b1)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int             rise_cyc [LOG];
    int             fall_cyc [LOG];
    int             brise_cyc[LOG];
    int             bfall_cyc[LOG];
    int             done_cyc [LOG];
    logic [IDW-1:0] done_idv [LOG];
    logic           done_okv [LOG];
    logic [RCW-1:0] done_rcv [LOG];
    int n_rise = 0, n_fall = 0, n_brise = 0, n_bfall = 0, n_done = 0;

    initial begin
        logic er_prev;
        logic busy_prev;
        er_prev   = 1'b0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.eth_reset === 1'b1 && er_prev !== 1'b1) begin
                if (n_rise < LOG) rise_cyc[n_rise] = cyc;
                n_rise++;
            end
            if (bus.eth_reset === 1'b0 && er_prev === 1'b1) begin
                if (n_fall < LOG) fall_cyc[n_fall] = cyc;
                n_fall++;
            end
            if (bus.busy === 1'b1 && busy_prev !== 1'b1) begin
                if (n_brise < LOG) brise_cyc[n_brise] = cyc;
                n_brise++;
            end
            if (bus.busy === 1'b0 && busy_prev === 1'b1) begin
                if (n_bfall < LOG) bfall_cyc[n_bfall] = cyc;
                n_bfall++;
            end
            if (bus.done === 1'b1) begin
                if (n_done < LOG) begin
                    done_cyc[n_done] = cyc;
                    done_idv[n_done] = bus.done_id;
                    done_okv[n_done] = bus.done_ok;
                    done_rcv[n_done] = bus.retry_count;
                end
                n_done++;
            end
            er_prev   = bus.eth_reset;
            busy_prev = bus.busy;
        end
    end

    task automatic wait_falls(input int target, output bit hit);
        for (int n = 0; n < 3000 && n_fall < target; n++) @(negedge clk);
        hit = (n_fall >= target);
    endtask

    task automatic wait_bfalls(input int target, output bit hit);
        for (int n = 0; n < 3000 && n_bfall < target; n++) @(negedge clk);
        hit = (n_bfall >= target);
    endtask

    task automatic wait_dones(input int target, output bit hit);
        for (int n = 0; n < 3000 && n_done < target; n++) @(negedge clk);
        hit = (n_done >= target);
    endtask

    task automatic pulse_req(input logic [NUM_REQ-1:0] v);
        @(negedge clk);
        bus.req = v;
        @(negedge clk);
        bus.req = '0;
    endtask

    task automatic set_cfg(input int ra, input int rw, input int rt, input int ho, input logic lu);
        bus.reset_after     = 14'(ra);
        bus.reset_width     = 14'(rw);
        bus.recover_timeout = 24'(rt);
        bus.holdoff         = 16'(ho);
        bus.link_up         = lu;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        bus.req = '0;
        bus.reset_after = '0;
        bus.reset_width = '0;
        bus.recover_timeout = '0;
        bus.holdoff = '0;
        bus.link_up = 1'b0;
        #2;
        tests++; if (bus.eth_reset !== 1'b0) begin fails++;
            $display("FAIL reset_eth_reset: got %b want 0", bus.eth_reset); end
        tests++; if (bus.busy !== 1'b0) begin fails++;
            $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.grant_id !== 2'd0) begin fails++;
            $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
        tests++; if (bus.done !== 1'b0) begin fails++;
            $display("FAIL reset_done: got %b want 0", bus.done); end
        tests++; if (bus.done_id !== 2'd0) begin fails++;
            $display("FAIL reset_done_id: got %0d want 0", bus.done_id); end
        tests++; if (bus.done_ok !== 1'b0) begin fails++;
            $display("FAIL reset_done_ok: got %b want 0", bus.done_ok); end
        tests++; if (bus.retry_count !== 2'd0) begin fails++;
            $display("FAIL reset_retry_count: got %0d want 0", bus.retry_count); end
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (bus.busy !== 1'b0 || n_brise != 0) begin fails++;
            $display("FAIL idle_after_reset: busy %b grants %0d want 0/0", bus.busy, n_brise); end
    endtask

    task automatic test_arbitration();
        int b_r, b_d, b_bf, n;
        bit hit;
        logic [IDW-1:0] exp_ids[4];
        exp_ids = '{2'd0, 2'd1, 2'd3, 2'd0};
        set_cfg(1, 1, 3, 1, 1'b0);
        b_r = n_rise; b_d = n_done; b_bf = n_bfall;
        pulse_req(4'b1011);
        n = 0;
        while (!(bus.busy === 1'b1 && bus.grant_id === 2'd1) && n < 1000) begin
            @(negedge clk); n++;
        end
        tests++; if (n >= 1000) begin fails++;
            $display("FAIL arb_grant1_timeout: waited %0d cycles want grant_id 1", n); end
        pulse_req(4'b0001);
        wait_bfalls(b_bf + 4, hit);
        tests++; if (!hit) begin fails++;
            $display("FAIL arb_timeout: sequences ended %0d want 4", n_bfall - b_bf); end
        repeat (10) @(negedge clk);
        tests++; if (n_done - b_d != 4) begin fails++;
            $display("FAIL arb_done_count: got %0d want 4", n_done - b_d); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (done_idv[b_d+i] !== exp_ids[i]) begin fails++;
                $display("FAIL arb_order[%0d]: got %0d want %0d", i, done_idv[b_d+i], exp_ids[i]); end
        end
        tests++; if (n_rise - b_r != 12) begin fails++;
            $display("FAIL arb_pulse_count: got %0d want 12", n_rise - b_r); end
        for (int i = 1; i < 12; i++) begin
            tests++; if (rise_cyc[b_r+i] <= fall_cyc[b_r+i-1]) begin fails++;
                $display("FAIL arb_overlap[%0d]: rise %0d prev fall %0d want rise later", i,
                         rise_cyc[b_r+i], fall_cyc[b_r+i-1]); end
        end
    endtask

    task automatic test_single_success();
        int b_r, b_f, b_d, b_br, b_bf, t_req, k, f;
        bit hit;
        set_cfg(3, 5, 100, 4, 1'b0);
        b_r = n_rise; b_f = n_fall; b_d = n_done; b_br = n_brise; b_bf = n_bfall;
        @(negedge clk);
        bus.req = 4'b0100;
        t_req = cyc + 1;
        @(negedge clk);
        bus.req = '0;
        wait_falls(b_f + 1, hit);
        tests++; if (!hit) begin fails++;
            $display("FAIL single_pulse_timeout: pulses ended %0d want 1", n_fall - b_f); end
        while (cyc < fall_cyc[b_f] + 10) @(negedge clk);
        bus.link_up = 1'b1;
        wait_bfalls(b_bf + 1, hit);
        tests++; if (!hit) begin fails++;
            $display("FAIL single_busy_timeout: busy never fell"); end
        k = brise_cyc[b_br];
        f = fall_cyc[b_f];
        tests++; if (k != t_req + 1) begin fails++;
            $display("FAIL single_busy_rise: got %0d want %0d", k, t_req + 1); end
        tests++; if (rise_cyc[b_r] != k + 4) begin fails++;
            $display("FAIL single_pulse_start: got %0d want %0d", rise_cyc[b_r], k + 4); end
        tests++; if (f != k + 9) begin fails++;
            $display("FAIL single_pulse_end: got %0d want %0d", f, k + 9); end
        tests++; if (n_rise - b_r != 1 || n_done - b_d != 1) begin fails++;
            $display("FAIL single_counts: pulses %0d dones %0d want 1/1", n_rise - b_r,
                     n_done - b_d); end
        tests++; if (done_cyc[b_d] != f + 13) begin fails++;
            $display("FAIL single_done_time: got %0d want %0d", done_cyc[b_d], f + 13); end
        tests++; if (done_idv[b_d] !== 2'd2 || done_okv[b_d] !== 1'b1 || done_rcv[b_d] !== 2'd0)
        begin fails++;
            $display("FAIL single_done_status: id %0d ok %b rc %0d want 2/1/0", done_idv[b_d],
                     done_okv[b_d], done_rcv[b_d]); end
        tests++; if (bfall_cyc[b_bf] != done_cyc[b_d] + 5) begin fails++;
            $display("FAIL single_busy_fall: got %0d want %0d", bfall_cyc[b_bf],
                     done_cyc[b_d] + 5); end
    endtask

    task automatic test_retry_exhaustion();
        int b_r, b_d, b_bf;
        bit hit;
        set_cfg(3, 2, 20, 2, 1'b1);
        b_r = n_rise; b_d = n_done; b_bf = n_bfall;
        pulse_req(4'b0010);
        wait_bfalls(b_bf + 1, hit);
        tests++; if (!hit) begin fails++;
            $display("FAIL retry_timeout: busy never fell"); end
        tests++; if (n_rise - b_r != 3) begin fails++;
            $display("FAIL retry_pulse_count: got %0d want 3", n_rise - b_r); end
        tests++; if (fall_cyc[b_r] - rise_cyc[b_r] != 2) begin fails++;
            $display("FAIL retry_width: got %0d want 2", fall_cyc[b_r] - rise_cyc[b_r]); end
        tests++; if (rise_cyc[b_r+1] != fall_cyc[b_r] + 25) begin fails++;
            $display("FAIL retry_gap1: got %0d want %0d", rise_cyc[b_r+1], fall_cyc[b_r] + 25); end
        tests++; if (rise_cyc[b_r+2] != fall_cyc[b_r+1] + 25) begin fails++;
            $display("FAIL retry_gap2: got %0d want %0d", rise_cyc[b_r+2],
                     fall_cyc[b_r+1] + 25); end
        tests++; if (done_cyc[b_d] != fall_cyc[b_r+2] + 21) begin fails++;
            $display("FAIL retry_done_time: got %0d want %0d", done_cyc[b_d],
                     fall_cyc[b_r+2] + 21); end
        tests++; if (done_idv[b_d] !== 2'd1 || done_okv[b_d] !== 1'b0 || done_rcv[b_d] !== 2'd2)
        begin fails++;
            $display("FAIL retry_done_status: id %0d ok %b rc %0d want 1/0/2", done_idv[b_d],
                     done_okv[b_d], done_rcv[b_d]); end
        tests++; if (bus.retry_count !== 2'd2) begin fails++;
            $display("FAIL retry_count_hold: got %0d want 2", bus.retry_count); end
    endtask

    task automatic test_back_to_back();
        int b_d, b_br, b_bf, n;
        bit hit;
        set_cfg(2, 4, 3, 1, 1'b0);
        b_d = n_done; b_br = n_brise; b_bf = n_bfall;
        pulse_req(4'b0010);
        n = 0;
        while (!(bus.eth_reset === 1'b1 && bus.grant_id === 2'd1) && n < 200) begin
            @(negedge clk); n++;
        end
        tests++; if (n >= 200) begin fails++;
            $display("FAIL rereq_assert_timeout: waited %0d cycles", n); end
        pulse_req(4'b0010);
        wait_bfalls(b_bf + 2, hit);
        tests++; if (!hit) begin fails++;
            $display("FAIL rereq_timeout: sequences ended %0d want 2", n_bfall - b_bf); end
        tests++; if (n_done - b_d != 2 || n_brise - b_br != 2) begin fails++;
            $display("FAIL rereq_counts: dones %0d grants %0d want 2/2", n_done - b_d,
                     n_brise - b_br); end
        tests++; if (done_idv[b_d] !== 2'd1 || done_idv[b_d+1] !== 2'd1) begin fails++;
            $display("FAIL rereq_ids: got %0d,%0d want 1,1", done_idv[b_d], done_idv[b_d+1]); end
        tests++; if (brise_cyc[b_br+1] != bfall_cyc[b_bf] + 1) begin fails++;
            $display("FAIL rereq_regrant: got %0d want %0d", brise_cyc[b_br+1],
                     bfall_cyc[b_bf] + 1); end
    endtask

    task automatic test_zero_config();
        int b_r, b_d, b_br, b_bf;
        bit hit;
        set_cfg(0, 0, 2, 0, 1'b1);
        b_r = n_rise; b_d = n_done; b_br = n_brise; b_bf = n_bfall;
        pulse_req(4'b1000);
        wait_bfalls(b_bf + 1, hit);
        tests++; if (!hit) begin fails++;
            $display("FAIL zero_timeout: busy never fell"); end
        tests++; if (rise_cyc[b_r] != brise_cyc[b_br] + 1) begin fails++;
            $display("FAIL zero_start: got %0d want %0d", rise_cyc[b_r], brise_cyc[b_br] + 1); end
        tests++; if (fall_cyc[b_r] - rise_cyc[b_r] != 1) begin fails++;
            $display("FAIL zero_width: got %0d want 1", fall_cyc[b_r] - rise_cyc[b_r]); end
        tests++; if (n_rise - b_r != 3) begin fails++;
            $display("FAIL zero_pulse_count: got %0d want 3", n_rise - b_r); end
        tests++; if (rise_cyc[b_r+1] != fall_cyc[b_r] + 4) begin fails++;
            $display("FAIL zero_gap: got %0d want %0d", rise_cyc[b_r+1], fall_cyc[b_r] + 4); end
        tests++; if (done_idv[b_d] !== 2'd3 || done_okv[b_d] !== 1'b0) begin fails++;
            $display("FAIL zero_done_status: id %0d ok %b want 3/0", done_idv[b_d],
                     done_okv[b_d]); end
        tests++; if (bfall_cyc[b_bf] != done_cyc[b_d] + 1) begin fails++;
            $display("FAIL zero_busy_fall: got %0d want %0d", bfall_cyc[b_bf],
                     done_cyc[b_d] + 1); end
    endtask

    task automatic test_midop_reset();
        int b_d, b_br, n;
        set_cfg(1, 10, 50, 1, 1'b0);
        b_d = n_done; b_br = n_brise;
        pulse_req(4'b0001);
        n = 0;
        while (bus.eth_reset !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        tests++; if (n >= 100) begin fails++;
            $display("FAIL midop_assert_timeout: waited %0d cycles", n); end
        pulse_req(4'b1000);
        #2;
        aresetn = 1'b0;
        #1;
        tests++; if (bus.eth_reset !== 1'b0) begin fails++;
            $display("FAIL midop_eth_reset: got %b want 0", bus.eth_reset); end
        tests++; if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL midop_busy_grant_done: got %b/%0d/%b want 0/0/0", bus.busy,
                     bus.grant_id, bus.done); end
        tests++; if (bus.done_id !== 2'd0 || bus.done_ok !== 1'b0 || bus.retry_count !== 2'd0)
        begin fails++;
            $display("FAIL midop_status: got %0d/%b/%0d want 0/0/0", bus.done_id, bus.done_ok,
                     bus.retry_count); end
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (20) @(negedge clk);
        tests++; if (n_done != b_d) begin fails++;
            $display("FAIL midop_no_done: got %0d dones want 0", n_done - b_d); end
        tests++; if (n_brise - b_br != 1 || bus.busy !== 1'b0 || bus.eth_reset !== 1'b0) begin
            fails++;
            $display("FAIL midop_idle_after: grants %0d busy %b eth_reset %b want 1/0/0",
                     n_brise - b_br, bus.busy, bus.eth_reset); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arbitration();
        test_single_success();
        test_retry_exhaustion();
        test_back_to_back();
        test_zero_config();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
